flex_timer_down: RTL
====================

# flex_timer_down

Programmable down-counting interval timer, the count-down counterpart to the team's up-counting flex counter. It loads a period value on a start pulse, decrements on each enabled cycle, and signals expiry when the period is exhausted. It supports both one-shot and auto-reload (periodic) operation. It sits beside the bit-period and timeout logic of the serial/bus peripherals, where a block needs "N enabled cycles from now" rather than "count up and roll over".

## Interface
- NUM_CNT_BITS, 4, width of counter and period value; period range 1..2^NUM_CNT_BITS
- clk  in  1  system clock; all state changes on rising edge
- n_rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear; highest-priority control
- start  in  1  single-cycle pulse; samples reload_val and begins counting
- count_enable  in  1  decrement qualifier, evaluated only in RUN
- auto_reload  in  1  1 = periodic, 0 = one-shot; sampled at each expiry
- reload_val  in  NUM_CNT_BITS  period; 0 encodes 2^NUM_CNT_BITS
- count_out  out  NUM_CNT_BITS  current remaining count (registered)
- expire_flag  out  1  one-cycle pulse, registered, marks period completion
- busy  out  1  high in RUN
- done  out  1  high in EXPIRED (one-shot finished, level)

## Operation
- The clock is clk. Reset n_rst is asynchronous and active-low.
- Reset values: state IDLE, count_out 0, expire_flag 0, busy 0, done 0.
- FSM states: IDLE, RUN, EXPIRED. busy and done are decoded from registered state, with no combinational path from inputs.
- Priority each cycle: clear > start > count_enable > hold.
- clear: next state IDLE, count_out 0, expire_flag 0, from any state.
- start: count_out <= reload_val, next state RUN, expire_flag 0.
  - This applies from IDLE, RUN (restart) or EXPIRED.
  - No decrement occurs on the start cycle.
- RUN with count_enable=1:
  - If count_out != 1: count_out <= count_out - 1, modulo 2^N. 0 wraps to all-ones, which implements the 2^N period.
  - If count_out == 1: expire_flag <= 1.
    - If auto_reload=1: count_out <= reload_val (freshly sampled), stay RUN.
    - Else: count_out <= 0, next state EXPIRED.
- RUN with count_enable=0: all registers hold. expire_flag <= 0.
- IDLE and EXPIRED: count_enable is ignored, count_out holds, expire_flag <= 0.
- Period rule: exactly P enabled RUN cycles elapse from start to expiry, where P = reload_val, or 2^N if reload_val = 0.

## Timing
- expire_flag rises on the edge following the enabled cycle where count_out == 1. It is coincident with count_out showing the reload value (periodic) or 0 plus done=1 (one-shot).
- expire_flag is high for exactly one cycle per expiry. It is never high in consecutive cycles unless P = 1 in periodic mode with continuous enable.
- Periodic mode with P=1 and count_enable held high: expire_flag is held high every cycle and count_out stays at 1.
- Start-to-busy latency: 1 cycle. count_out shows the loaded value on the cycle after start.
- start on the expiring cycle: start wins. The timer reloads and expire_flag is 0 next cycle, so no expiry is reported.
- clear and start in the same cycle: clear wins, result IDLE.
- Changing auto_reload mid-period takes effect at the next expiry only.
- Changing reload_val mid-period does not affect the current period.
- n_rst asserted mid-count: all outputs go to reset values immediately, without waiting for clk.

## Structure
- Shared package holds the state enum (IDLE, RUN, EXPIRED, 2-bit encoding 00/01/10).
- The 11 encoding is illegal and recovers to IDLE on the next edge.
- One sub-module is natural: flex_timer_down_dec, a parameterized combinational decrementer (borrow chain) producing count-1 and an is_one flag.
- The FSM and registers live in the top module.

## Test plan
- Reset: hold n_rst=0 mid-count → count_out=0, expire_flag=0, busy=0, done=0 asynchronously. Release → stay IDLE.
- One-shot, N=4:
  - Stimulus: reload_val=3, start, count_enable=1.
  - count_out sequence: 3,2,1,0.
  - expire_flag high exactly on the cycle count_out first reads 0.
  - done=1 thereafter, busy=0.
- Periodic:
  - Stimulus: reload_val=2, auto_reload=1, enable continuous.
  - count_out: 2,1,2,1,…
  - expire_flag pulses every 2 cycles, coincident with count_out=2.
- Gapped enable:
  - Stimulus: reload_val=4, toggle count_enable 1,0,1,0….
  - Expiry after exactly 4 enabled cycles (8 clocks).
  - count_out holds during disabled cycles.
- Full period: reload_val=0 one-shot → count_out 0,15,14,…,1,0. Expiry after exactly 16 enabled cycles.
- Collisions:
  - start on the expiring cycle → no expire_flag, count_out = new reload_val.
  - clear+start together → IDLE, count_out=0.
  - start while EXPIRED → RUN, done=0.

Source files
------------

// File: rtl/flex_timer_down_pkg.sv
// Shared types for the down-counting interval timer.
package flex_timer_down_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } timer_state_e;

endpackage

// File: rtl/flex_timer_down_dec.sv
// Combinational decrementer: ripple-borrow count-1 plus an "equals one" flag.
module flex_timer_down_dec #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic [NUM_CNT_BITS-1:0] count,
    output logic [NUM_CNT_BITS-1:0] count_dec,
    output logic                    is_one
);

    logic [NUM_CNT_BITS:0] borrow;

    assign borrow[0] = 1'b1;

    // A bit flips while a borrow reaches it; the borrow continues only past zeros.
    for (genvar gi = 0; gi < NUM_CNT_BITS; gi++) begin : g_borrow
        assign count_dec[gi]  = count[gi] ^ borrow[gi];
        assign borrow[gi + 1] = borrow[gi] & ~count[gi];
    end

    assign is_one = (count == NUM_CNT_BITS'(1));

endmodule

// File: rtl/flex_timer_down.sv
// Programmable down-counting interval timer with one-shot and periodic modes.
module flex_timer_down
    import flex_timer_down_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    count_enable,
    input  logic                    auto_reload,
    input  logic [NUM_CNT_BITS-1:0] reload_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire_flag,
    output logic                    busy,
    output logic                    done
);

    timer_state_e            state_reg, state_next;
    logic [NUM_CNT_BITS-1:0] count_reg, count_next;
    logic                    expire_reg, expire_next;
    logic [NUM_CNT_BITS-1:0] count_dec;
    logic                    count_is_one;

    flex_timer_down_dec #(
        .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_dec (
        .count     (count_reg),
        .count_dec (count_dec),
        .is_one    (count_is_one)
    );

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        expire_next = 1'b0;

        if (clear) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else if (start) begin
            state_next = ST_RUN;
            count_next = reload_val;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (count_enable) begin
                        if (count_is_one) begin
                            expire_next = 1'b1;
                            if (auto_reload) begin
                                count_next = reload_val;
                            end else begin
                                count_next = '0;
                                state_next = ST_EXPIRED;
                            end
                        end else begin
                            // Loading 0 wraps to all-ones here, giving the 2^N period.
                            count_next = count_dec;
                        end
                    end
                end
                ST_IDLE, ST_EXPIRED: begin
                    state_next = state_reg;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            expire_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            expire_reg <= expire_next;
        end
    end

    assign count_out   = count_reg;
    assign expire_flag = expire_reg;
    assign busy        = (state_reg == ST_RUN);
    assign done        = (state_reg == ST_EXPIRED);

endmodule
